// File: rtl/uart_param.sv
// -----------------------------------------------------------------------------
// uart_param
//
// Parametrised full-duplex UART core, clocked from the 100 MHz system clock.
// Bit timing comes from a per-bit cycle count (CLK_DIV), not a divided clock.
//
// Parameters
//   CLK_DIV    clk_100 cycles per bit (>= 8)
//   DATA_BITS  payload width, 5..9, LSB first
//   STOP_BITS  stop bits transmitted (1 or 2); receiver checks only the first
//   PARITY_ODD 0 = even parity, 1 = odd parity (used with UART_PARITY_EN)
//
// Build option
//   UART_PARITY_EN  when defined, both FSMs carry a parity bit after the data.
//                   When undefined, frames are start + data + stop and
//                   parity_err is tied low.
//
// Ports
//   clk_100      system clock
//   rst          asynchronous active-high reset
//   send         transmit request, accepted while the transmitter is idle
//   data_in      transmit payload, latched on accept
//   busy         transmitter occupied
//   tx           serial output, idle high
//   led_tx       copy of busy
//   rx           serial input (asynchronous, synchronised internally)
//   data_out     last received word
//   ready        received word valid, sticky until clr
//   clr          clears ready and all error flags
//   frame_err    sticky: first stop bit sampled low
//   parity_err   sticky: parity mismatch
//   overrun_err  sticky: word completed while ready was already set
//   led_rx       high while the receiver is not idle
//
// FSM states (both directions)
//   state    | meaning
//   IDLE     | TX: waiting for send          RX: waiting for a falling edge
//   START    | TX: driving the start bit     RX: half-bit wait, start re-check
//   DATA     | TX: shifting out data bits    RX: sampling data bits
//   PARITY   | TX: driving the parity bit    RX: sampling the parity bit
//   STOP     | TX: driving stop bit(s)       RX: sampling the first stop bit
// -----------------------------------------------------------------------------
module uart_param #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_100,
    input  logic                 rst,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 busy,
    output logic                 tx,
    output logic                 led_tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 ready,
    input  logic                 clr,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 led_rx
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = 4;

    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST   = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic       PAR_ODD  = (PARITY_ODD != 0);
`endif

    // -------------------------------------------------------------------------
    // Transmitter
    // -------------------------------------------------------------------------
    logic [2:0]           tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [BIT_W-1:0]     tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_tick;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_tick = (tx_cnt == '0);

    // tx is a flop with async preset so it returns high the moment rst rises.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            if (tx_state != S_IDLE) begin
                tx_cnt <= tx_tick ? BIT_RELOAD : tx_cnt - CNT_W'(1);
            end
            case (tx_state)
                S_IDLE: begin
                    if (send) begin
                        tx_state <= S_START;
                        tx_cnt   <= BIT_RELOAD;
                        tx_bit   <= '0;
                        tx_shift <= data_in;
                        tx       <= 1'b0;
`ifdef UART_PARITY_EN
                        tx_par   <= (^data_in) ^ PAR_ODD;
`endif
                    end
                end
                S_START: begin
                    if (tx_tick) begin
                        tx_state <= S_DATA;
                        tx       <= tx_shift[0];
                    end
                end
                S_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit == DATA_LAST) begin
                            tx_bit <= '0;
`ifdef UART_PARITY_EN
                            tx_state <= S_PARITY;
                            tx       <= tx_par;
`else
                            tx_state <= S_STOP;
                            tx       <= 1'b1;
`endif
                        end else begin
                            tx_bit   <= tx_bit + BIT_W'(1);
                            tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                            tx       <= tx_shift[1];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (tx_tick) begin
                        tx_state <= S_STOP;
                        tx       <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tx_tick) begin
                        if (tx_bit == STOP_LAST) begin
                            tx_state <= S_IDLE;
                            tx_bit   <= '0;
                        end else begin
                            tx_bit <= tx_bit + BIT_W'(1);
                        end
                        tx <= 1'b1;
                    end
                end
                default: begin
                    tx_state <= S_IDLE;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

    assign busy   = (tx_state != S_IDLE);
    assign led_tx = busy;

    // -------------------------------------------------------------------------
    // Receiver input synchroniser; rx_prev gives the edge reference.
    // -------------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic rx_fall;

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    // -------------------------------------------------------------------------
    // Receiver FSM
    // -------------------------------------------------------------------------
    logic [2:0]           rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_tick;
    logic                 rx_commit;
    logic                 rx_frame_bad;
`ifdef UART_PARITY_EN
    logic                 rx_par_bad;
`endif

    assign rx_tick = (rx_cnt == '0);

    // Errors found during a frame are held here and only raised on the
    // commit cycle, so a clr landing on that cycle keeps this word's flags.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_commit    <= 1'b0;
            rx_frame_bad <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad   <= 1'b0;
`endif
        end else begin
            rx_commit <= 1'b0;
            if (rx_state != S_IDLE) begin
                rx_cnt <= rx_tick ? BIT_RELOAD : rx_cnt - CNT_W'(1);
            end
            case (rx_state)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= S_START;
                        rx_cnt   <= HALF_RELOAD;
                        rx_bit   <= '0;
                    end
                end
                S_START: begin
                    if (rx_tick) begin
                        // A line already back high at mid-start is a glitch.
                        rx_state <= rx_sync ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == DATA_LAST) begin
                            rx_bit <= '0;
`ifdef UART_PARITY_EN
                            rx_state <= S_PARITY;
`else
                            rx_state <= S_STOP;
`endif
                        end else begin
                            rx_bit <= rx_bit + BIT_W'(1);
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (rx_tick) begin
                        rx_par_bad <= rx_sync ^ (^rx_shift) ^ PAR_ODD;
                        rx_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (rx_tick) begin
                        // Rearm immediately; the rest of the stop bit is not waited out.
                        rx_frame_bad <= ~rx_sync;
                        rx_commit    <= 1'b1;
                        rx_state     <= S_IDLE;
                    end
                end
                default: begin
                    rx_state <= S_IDLE;
                end
            endcase
        end
    end

    assign led_rx = (rx_state != S_IDLE);

    // -------------------------------------------------------------------------
    // Received word and sticky status; a commit takes priority over clr.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            data_out    <= '0;
            ready       <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (rx_commit) begin
            data_out    <= rx_shift;
            ready       <= 1'b1;
            frame_err   <= (frame_err & ~clr) | rx_frame_bad;
            overrun_err <= (overrun_err & ~clr) | ready;
        end else if (clr) begin
            ready       <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (rx_commit) begin
            parity_err <= (parity_err & ~clr) | rx_par_bad;
        end else if (clr) begin
            parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_param.sv
`timescale 1ns/1ps
module tb_uart_param;

    localparam int CLK_DIV    = 16;
    localparam int DW         = 8;
    localparam int STOP_BITS  = 1;
    localparam int PARITY_ODD = 0;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS      = 1 + DW + PB + STOP_BITS;
    localparam int FRAME      = NBITS * CLK_DIV;
    // Cycle (counted from the pin's falling edge) on which ready is committed:
    // start re-check at CLK_DIV/2+2, then one sample per bit through the stop bit, +1.
    localparam int COMMIT_IDX = CLK_DIV / 2 + 2 + CLK_DIV * (1 + DW + PB) + 1;

    logic          clk_100 = 1'b0;
    logic          rst     = 1'b1;
    logic          send    = 1'b0;
    logic          clr     = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          busy, tx, led_tx, ready, frame_err, parity_err, overrun_err, led_rx;
    logic [DW-1:0] data_out;
    logic          rx_drv  = 1'b1;
    logic          loop_en = 1'b0;
    logic          rx_line;

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk_100 = ~clk_100;

    uart_param #(
        .CLK_DIV    (CLK_DIV),
        .DATA_BITS  (DW),
        .STOP_BITS  (STOP_BITS),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk_100     (clk_100),
        .rst         (rst),
        .send        (send),
        .data_in     (data_in),
        .busy        (busy),
        .tx          (tx),
        .led_tx      (led_tx),
        .rx          (rx_line),
        .data_out    (data_out),
        .ready       (ready),
        .clr         (clr),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .led_rx      (led_rx)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic          rdy;
        logic [DW-1:0] data;
        logic          fe;
        logic          pe;
        logic          ov;
    } rx_exp_t;

    rx_exp_t       rx_q[$];
    logic [DW-1:0] tx_q[$];

    // Behavioural receiver status model
    logic          m_ready = 1'b0, m_fe = 1'b0, m_pe = 1'b0, m_ov = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic          tx_mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit idx of a serial frame: start, data LSB first, [parity], stop(s)
    function automatic logic frame_bit(input logic [DW-1:0] d, input int idx, input logic par_flip);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return d[idx-1];
        if (PB == 1 && idx == DW + 1) return (^d) ^ (PARITY_ODD != 0) ^ par_flip;
        return 1'b1;
    endfunction

    // ---------------------------------------------------------------- TX monitor
    always begin : tx_monitor
        @(negedge clk_100);
        if (tx_mon_en && busy === 1'b1) begin
            logic [DW-1:0] d;
            int            first_bad;
            bit            busy_bad;
            d = '0;
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected_frame: busy rose with no queued send at %0t", $time);
            end else begin
                d = tx_q.pop_front();
            end
            first_bad = -1;
            busy_bad  = 1'b0;
            for (int i = 0; i < FRAME; i++) begin
                if (i > 0) @(negedge clk_100);
                if (first_bad < 0 && tx !== frame_bit(d, i / CLK_DIV, 1'b0)) first_bad = i;
                if (busy !== 1'b1 || led_tx !== 1'b1) busy_bad = 1'b1;
            end
            check("tx_frame_first_bad_cycle", first_bad, -1);
            check("tx_busy_held_whole_frame", busy_bad, 0);
            @(negedge clk_100);
            check("tx_busy_fall_after_frame", {busy, led_tx}, 2'b00);
        end
    end

    // ---------------------------------------------------------------- RX monitor
    logic led_rx_prev = 1'b0;
    always begin : rx_monitor
        @(negedge clk_100);
        if (led_rx_prev === 1'b1 && led_rx === 1'b0 && rst === 1'b0) begin
            rx_exp_t e;
            @(negedge clk_100);
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected_episode: receiver went idle with nothing queued at %0t", $time);
            end else begin
                e = rx_q.pop_front();
                check("rx_ready", ready, e.rdy);
                check("rx_data_out", data_out, e.data);
                check("rx_frame_err", frame_err, e.fe);
                check("rx_parity_err", parity_err, e.pe);
                check("rx_overrun_err", overrun_err, e.ov);
            end
        end
        led_rx_prev = led_rx;
    end

    // ---------------------------------------------------------------- stimulus helpers
    task automatic push_rx(input logic rdy);
        rx_exp_t e;
        e.rdy  = rdy;
        e.data = m_data;
        e.fe   = m_fe;
        e.pe   = m_pe;
        e.ov   = m_ov;
        rx_q.push_back(e);
    endtask

    task automatic expect_word(input logic [DW-1:0] d, input logic stop_ok,
                               input logic par_flip, input logic clr_hit);
        if (clr_hit) begin
            m_fe = 1'b0;
            m_pe = 1'b0;
            m_ov = 1'b0;
        end
        m_ov    = m_ov | m_ready;
        m_fe    = m_fe | ~stop_ok;
        m_pe    = m_pe | ((PB == 1) ? par_flip : 1'b0);
        m_ready = 1'b1;
        m_data  = d;
        push_rx(1'b1);
    endtask

    task automatic rx_frame(input logic [DW-1:0] d, input logic stop_ok,
                            input logic par_flip, input logic clr_hit);
        logic b;
        expect_word(d, stop_ok, par_flip, clr_hit);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk_100);
            b = frame_bit(d, i / CLK_DIV, par_flip);
            if (i / CLK_DIV == 1 + DW + PB && !stop_ok) b = 1'b0;
            rx_drv = b;
            clr    = (clr_hit && i == COMMIT_IDX);
        end
        @(negedge clk_100);
        rx_drv = 1'b1;
        clr    = 1'b0;
        repeat (CLK_DIV) @(negedge clk_100);
    endtask

    task automatic do_clr();
        @(negedge clk_100);
        clr = 1'b1;
        @(negedge clk_100);
        clr = 1'b0;
        check("clr_clears_status", {ready, frame_err, parity_err, overrun_err}, 4'b0000);
        m_ready = 1'b0;
        m_fe    = 1'b0;
        m_pe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic tx_send(input logic [DW-1:0] d);
        int n = 0;
        @(negedge clk_100);
        while (busy !== 1'b0 && n < 4 * FRAME) begin
            @(negedge clk_100);
            n++;
        end
        check("tx_send_wait_idle_in_time", (n < 4 * FRAME), 1);
        send    = 1'b1;
        data_in = d;
        tx_q.push_back(d);
        @(negedge clk_100);
        send = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 2 * FRAME) begin
            @(negedge clk_100);
            n++;
        end
        check("tx_finishes_in_time", (n < 2 * FRAME), 1);
        repeat (3) @(negedge clk_100);
    endtask

    task automatic loopback(input logic [DW-1:0] d);
        loop_en = 1'b1;
        expect_word(d, 1'b1, 1'b0, 1'b0);
        tx_send(d);
        wait_tx_idle();
        repeat (CLK_DIV) @(negedge clk_100);
        loop_en = 1'b0;
    endtask

    // ---------------------------------------------------------------- main sequence
    initial begin
        logic [DW-1:0] rd, rd2;
        int            n;
        int            sel;

        repeat (3) @(negedge clk_100);
        check("reset_tx_busy_ledtx", {tx, busy, led_tx}, 3'b100);
        check("reset_rx_status", {ready, frame_err, parity_err, overrun_err, led_rx}, 5'b00000);
        check("reset_data_out", data_out, 0);
        rst = 1'b0;
        @(negedge clk_100);
        check("post_reset_tx_busy", {tx, busy}, 2'b10);

        // Single frame 8'hA5
        tx_send(8'hA5);
        wait_tx_idle();

        // Send held through a frame: data change while busy is ignored,
        // the next word is accepted on the first idle cycle.
        @(negedge clk_100);
        send    = 1'b1;
        data_in = 8'h96;
        tx_q.push_back(8'h96);
        @(negedge clk_100);
        data_in = 8'h4B;
        tx_q.push_back(8'h4B);
        n = 0;
        while (busy !== 1'b0 && n < 2 * FRAME) begin
            @(negedge clk_100);
            n++;
        end
        check("b2b_first_frame_ends", (n < 2 * FRAME), 1);
        @(negedge clk_100);
        check("b2b_reaccept_next_cycle", busy, 1);
        send = 1'b0;
        wait_tx_idle();

        // Reset in the middle of data bit 4 of 8'hA5 (that bit is 0)
        tx_mon_en = 1'b0;
        @(negedge clk_100);
        send    = 1'b1;
        data_in = 8'hA5;
        @(negedge clk_100);
        send = 1'b0;
        repeat ((1 + 4) * CLK_DIV + CLK_DIV / 2 - 1) @(negedge clk_100);
        check("mid_tx_line_before_reset", {tx, busy}, 2'b01);
        #2 rst = 1'b1;
        #1;
        check("async_reset_tx_busy", {tx, busy, led_tx}, 3'b100);
        @(negedge clk_100);
        @(negedge clk_100);
        rst     = 1'b0;
        m_ready = 1'b0;
        m_fe    = 1'b0;
        m_pe    = 1'b0;
        m_ov    = 1'b0;
        m_data  = '0;
        tx_mon_en = 1'b1;
        tx_send(8'hC3);
        wait_tx_idle();

        // Loopback 8'h3C then clr
        loopback(8'h3C);
        do_clr();

        // Short low glitch on rx: receiver returns to idle with nothing committed
        push_rx(m_ready);
        @(negedge clk_100);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk_100);
        @(negedge clk_100);
        rx_drv = 1'b1;
        check("glitch_led_rx_raised", led_rx, 1);
        n = 0;
        while (led_rx !== 1'b0 && n < 10) begin
            @(negedge clk_100);
            n++;
        end
        check("glitch_led_rx_falls_within_10", (n < 10), 1);
        repeat (CLK_DIV) @(negedge clk_100);
        check("glitch_ready_stays_low", ready, 0);

        // Framing error then two words without clr (overrun)
        do_clr();
        rx_frame(8'h55, 1'b0, 1'b0, 1'b0);
        rx_frame(8'h81, 1'b1, 1'b0, 1'b0);
        rx_frame(8'h7E, 1'b1, 1'b0, 1'b0);

        // clr on the commit cycle: older frame_err cleared, this word's flags kept
        rx_frame(8'hE1, 1'b1, 1'b0, 1'b1);
        do_clr();
        rx_frame(8'h2D, 1'b0, 1'b0, 1'b1);

`ifdef UART_PARITY_EN
        do_clr();
        rx_frame(8'h07, 1'b1, 1'b1, 1'b0);
        do_clr();
        rx_frame(8'h07, 1'b1, 1'b0, 1'b0);
`endif

        // Randomised mix
        for (int k = 0; k < 12; k++) begin
            rd  = DW'($urandom);
            rd2 = DW'($urandom);
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin
                    if ($urandom_range(0, 2) == 0) do_clr();
                    rx_frame(rd, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 3) == 0));
                end
                1: loopback(rd);
                2: begin
                    fork
                        tx_send(rd);
                        rx_frame(rd2, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0);
                    join
                    wait_tx_idle();
                end
                default: begin
                    do_clr();
                    rx_frame(rd, 1'b1, 1'b0, 1'b0);
                end
            endcase
        end

        repeat (3 * CLK_DIV) @(negedge clk_100);
        check("rx_queue_drained", rx_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
